// File: rtl/mu_gate_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mu_gate_scheduler
//
// Purpose
//   Shares the single mu_core cost/partition gate among NREQ instruction
//   requesters. One instruction is in flight at a time. Each one is granted
//   round-robin, issued to the gate, and its gate decision is sampled. If the
//   gate asks for one, a receipt is fetched from the u-ALU and presented back
//   to the gate. The verdict is then returned to the requester. The scheduler
//   holds gate_instr_valid low for at least two cycles between instructions,
//   so the gate's rising-edge detect re-arms.
//
// Parameters
//   NREQ     number of requesters (2..8)
//   TIMEOUT  cycles to wait for alu_rcpt_ack before aborting (>= 1)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_instr/req_cost    per-requester instruction offer
//                                   (slice [32*i+:32])
//   req_ready                       one-hot, one-cycle accept pulse
//   rsp_valid/rsp_allowed/rsp_status
//                                   one-hot completion pulse and its verdict
//   gate_*  (out)                   instruction, cost and receipt driven
//                                   towards mu_core
//   gate_*  (in)                    decision and status returned by mu_core
//   alu_rcpt_req/ack/value          level request / ack handshake with the
//                                   u-ALU
//   busy                            an instruction is in flight
//   stat_issued/stat_denied         saturating event counters
// -----------------------------------------------------------------------------
module mu_gate_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [32*NREQ-1:0]  req_instr,
    input  logic [32*NREQ-1:0]  req_cost,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic                rsp_allowed,
    output logic [31:0]         rsp_status,
    output logic [31:0]         gate_instruction,
    output logic [31:0]         gate_proposed_cost,
    output logic                gate_instr_valid,
    input  logic                gate_instr_allowed,
    input  logic                gate_receipt_required,
    input  logic                gate_cost_open,
    input  logic                gate_partition_open,
    input  logic                gate_receipt_accepted,
    input  logic [31:0]         gate_core_status,
    output logic [31:0]         gate_receipt_value,
    output logic                gate_receipt_valid,
    output logic                alu_rcpt_req,
    input  logic                alu_rcpt_ack,
    input  logic [31:0]         alu_rcpt_value,
    output logic                busy,
    output logic [15:0]         stat_issued,
    output logic [15:0]         stat_denied
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // The wait timer only ever holds 0..TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [31:0]   SEQ_TIMEOUT = 32'h0000_0010;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_ISSUE        = 3'd1;
    localparam logic [2:0] S_EVAL         = 3'd2;
    localparam logic [2:0] S_RCPT_WAIT    = 3'd3;
    localparam logic [2:0] S_RCPT_PRESENT = 3'd4;
    localparam logic [2:0] S_RCPT_CHECK   = 3'd5;
    localparam logic [2:0] S_RESP         = 3'd6;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    logic [2:0]      state_reg,              state_next;
    logic [GW-1:0]   last_grant_reg,         last_grant_next;
    logic [GW-1:0]   grant_reg,              grant_next;
    logic [TW-1:0]   timer_reg,              timer_next;
    logic            verdict_reg,            verdict_next;
    logic [31:0]     status_reg,             status_next;
    logic [NREQ-1:0] req_ready_reg,          req_ready_next;
    logic [NREQ-1:0] rsp_valid_reg,          rsp_valid_next;
    logic            rsp_allowed_reg,        rsp_allowed_next;
    logic [31:0]     rsp_status_reg,         rsp_status_next;
    logic [31:0]     gate_instruction_reg,   gate_instruction_next;
    logic [31:0]     gate_cost_reg,          gate_cost_next;
    logic            gate_instr_valid_reg,   gate_instr_valid_next;
    logic [31:0]     gate_rcpt_value_reg,    gate_rcpt_value_next;
    logic            gate_rcpt_valid_reg,    gate_rcpt_valid_next;
    logic            alu_rcpt_req_reg,       alu_rcpt_req_next;
    logic            busy_reg,               busy_next;
    logic [15:0]     stat_issued_reg,        stat_issued_next;
    logic [15:0]     stat_denied_reg,        stat_denied_next;

    // ------------------------------------------------------------------
    // Round-robin arbiter.
    // Requesters above the last grant take priority over those at or
    // below it. Within each group, the lowest index wins. This is the
    // same as searching upward from last_grant+1 with wrap-around.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] upper_mask;
    logic            upper_any;
    logic            grant_any;
    logic [GW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_onehot;
    logic [NREQ-1:0] rsp_onehot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_upper
            assign upper_mask[gi] = req_valid[gi] && (GW'(gi) > last_grant_reg);
        end
    endgenerate

    assign upper_any = |upper_mask;
    assign grant_any = |req_valid;

    always_comb begin
        grant_idx = '0;
        // Descending scan: the last hit is the lowest eligible index.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (upper_any ? upper_mask[j] : req_valid[j]) begin
                grant_idx = GW'(j);
            end
        end
    end

    assign grant_onehot = NREQ'(1) << grant_idx;
    assign rsp_onehot   = NREQ'(1) << grant_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next            = state_reg;
        last_grant_next       = last_grant_reg;
        grant_next            = grant_reg;
        timer_next            = timer_reg;
        verdict_next          = verdict_reg;
        status_next           = status_reg;
        gate_instruction_next = gate_instruction_reg;
        gate_cost_next        = gate_cost_reg;
        gate_instr_valid_next = gate_instr_valid_reg;
        gate_rcpt_value_next  = gate_rcpt_value_reg;
        alu_rcpt_req_next     = alu_rcpt_req_reg;
        busy_next             = busy_reg;
        stat_issued_next      = stat_issued_reg;
        stat_denied_next      = stat_denied_reg;
        // Pulse outputs default low; they are high for one cycle only.
        req_ready_next        = '0;
        rsp_valid_next        = '0;
        rsp_allowed_next      = 1'b0;
        rsp_status_next       = '0;
        gate_rcpt_valid_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (grant_any) begin
                    grant_next            = grant_idx;
                    last_grant_next       = grant_idx;
                    req_ready_next        = grant_onehot;
                    gate_instruction_next = req_instr[32*grant_idx +: 32];
                    gate_cost_next        = req_cost[32*grant_idx +: 32];
                    gate_instr_valid_next = 1'b1;
                    busy_next             = 1'b1;
                    if (stat_issued_reg != 16'hFFFF) begin
                        stat_issued_next = stat_issued_reg + 16'd1;
                    end
                    state_next = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The gate sees the instruction this cycle. Its outputs are
                // settled by the time they are sampled in EVAL.
                state_next = S_EVAL;
            end

            S_EVAL: begin
                if (gate_receipt_required) begin
                    timer_next        = '0;
                    alu_rcpt_req_next = 1'b1;
                    state_next        = S_RCPT_WAIT;
                end else begin
                    verdict_next          = gate_instr_allowed & gate_cost_open
                                            & gate_partition_open;
                    status_next           = gate_core_status;
                    gate_instr_valid_next = 1'b0;
                    state_next            = S_RESP;
                end
            end

            S_RCPT_WAIT: begin
                // An ack in the final allowed cycle still counts.
                if (alu_rcpt_ack) begin
                    gate_rcpt_value_next = alu_rcpt_value;
                    gate_rcpt_valid_next = 1'b1;
                    alu_rcpt_req_next    = 1'b0;
                    state_next           = S_RCPT_PRESENT;
                end else if (timer_reg == TIMER_LAST) begin
                    verdict_next          = 1'b0;
                    status_next           = SEQ_TIMEOUT;
                    alu_rcpt_req_next     = 1'b0;
                    gate_instr_valid_next = 1'b0;
                    state_next            = S_RESP;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            S_RCPT_PRESENT: begin
                state_next = S_RCPT_CHECK;
            end

            S_RCPT_CHECK: begin
                verdict_next          = gate_receipt_accepted;
                status_next           = gate_core_status;
                gate_instr_valid_next = 1'b0;
                state_next            = S_RESP;
            end

            S_RESP: begin
                // gate_instr_valid is already low here. It stays low through
                // the following IDLE cycle, giving a gap of at least 2 cycles.
                rsp_valid_next   = rsp_onehot;
                rsp_allowed_next = verdict_reg;
                rsp_status_next  = status_reg;
                if (!verdict_reg && (stat_denied_reg != 16'hFFFF)) begin
                    stat_denied_next = stat_denied_reg + 16'd1;
                end
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end

            default: begin
                gate_instr_valid_next = 1'b0;
                alu_rcpt_req_next     = 1'b0;
                busy_next             = 1'b0;
                state_next            = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset aborts any in-flight instruction without a response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= S_IDLE;
            last_grant_reg       <= GW'(NREQ - 1);
            grant_reg            <= '0;
            timer_reg            <= '0;
            verdict_reg          <= 1'b0;
            status_reg           <= '0;
            req_ready_reg        <= '0;
            rsp_valid_reg        <= '0;
            rsp_allowed_reg      <= 1'b0;
            rsp_status_reg       <= '0;
            gate_instruction_reg <= '0;
            gate_cost_reg        <= '0;
            gate_instr_valid_reg <= 1'b0;
            gate_rcpt_value_reg  <= '0;
            gate_rcpt_valid_reg  <= 1'b0;
            alu_rcpt_req_reg     <= 1'b0;
            busy_reg             <= 1'b0;
            stat_issued_reg      <= '0;
            stat_denied_reg      <= '0;
        end else begin
            state_reg            <= state_next;
            last_grant_reg       <= last_grant_next;
            grant_reg            <= grant_next;
            timer_reg            <= timer_next;
            verdict_reg          <= verdict_next;
            status_reg           <= status_next;
            req_ready_reg        <= req_ready_next;
            rsp_valid_reg        <= rsp_valid_next;
            rsp_allowed_reg      <= rsp_allowed_next;
            rsp_status_reg       <= rsp_status_next;
            gate_instruction_reg <= gate_instruction_next;
            gate_cost_reg        <= gate_cost_next;
            gate_instr_valid_reg <= gate_instr_valid_next;
            gate_rcpt_value_reg  <= gate_rcpt_value_next;
            gate_rcpt_valid_reg  <= gate_rcpt_valid_next;
            alu_rcpt_req_reg     <= alu_rcpt_req_next;
            busy_reg             <= busy_next;
            stat_issued_reg      <= stat_issued_next;
            stat_denied_reg      <= stat_denied_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready          = req_ready_reg;
    assign rsp_valid          = rsp_valid_reg;
    assign rsp_allowed        = rsp_allowed_reg;
    assign rsp_status         = rsp_status_reg;
    assign gate_instruction   = gate_instruction_reg;
    assign gate_proposed_cost = gate_cost_reg;
    assign gate_instr_valid   = gate_instr_valid_reg;
    assign gate_receipt_value = gate_rcpt_value_reg;
    assign gate_receipt_valid = gate_rcpt_valid_reg;
    assign alu_rcpt_req       = alu_rcpt_req_reg;
    assign busy               = busy_reg;
    assign stat_issued        = stat_issued_reg;
    assign stat_denied        = stat_denied_reg;

endmodule

// File: tb/tb_mu_gate_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mu_gate_scheduler
//
// Requester threads issue instructions and push the expected response for
// each one into a scoreboard queue. A monitor pops the queue and compares
// whenever rsp_valid pulses.
//
// The mu_core stand-in decodes its decision from fields of the instruction,
// so the expected outcome follows directly from those fields:
//   [0] allowed  [1] cost_open  [2] partition_open  [3] receipt_required
//   [4] receipt_accepted  [12:8] u-ALU ack delay  [31:16] core status
// -----------------------------------------------------------------------------
module tb_mu_gate_scheduler;
    localparam int          NREQ        = 4;
    localparam int          TIMEOUT     = 16;
    localparam logic [31:0] SEQ_TIMEOUT = 32'h0000_0010;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [32*NREQ-1:0]  req_instr;
    logic [32*NREQ-1:0]  req_cost;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     rsp_valid;
    logic                rsp_allowed;
    logic [31:0]         rsp_status;
    logic [31:0]         gate_instruction;
    logic [31:0]         gate_proposed_cost;
    logic                gate_instr_valid;
    logic                gate_instr_allowed;
    logic                gate_receipt_required;
    logic                gate_cost_open;
    logic                gate_partition_open;
    logic                gate_receipt_accepted;
    logic [31:0]         gate_core_status;
    logic [31:0]         gate_receipt_value;
    logic                gate_receipt_valid;
    logic                alu_rcpt_req;
    logic                alu_rcpt_ack;
    logic [31:0]         alu_rcpt_value;
    logic                busy;
    logic [15:0]         stat_issued;
    logic [15:0]         stat_denied;

    logic        rv [NREQ];
    logic [31:0] ri [NREQ];
    logic [31:0] rc [NREQ];

    always_comb begin
        req_valid = '0;
        req_instr = '0;
        req_cost  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = rv[i];
            req_instr[32*i +: 32] = ri[i];
            req_cost[32*i +: 32]  = rc[i];
        end
    end

    mu_gate_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_instr(req_instr), .req_cost(req_cost),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_allowed(rsp_allowed), .rsp_status(rsp_status),
        .gate_instruction(gate_instruction), .gate_proposed_cost(gate_proposed_cost),
        .gate_instr_valid(gate_instr_valid), .gate_instr_allowed(gate_instr_allowed),
        .gate_receipt_required(gate_receipt_required), .gate_cost_open(gate_cost_open),
        .gate_partition_open(gate_partition_open),
        .gate_receipt_accepted(gate_receipt_accepted),
        .gate_core_status(gate_core_status), .gate_receipt_value(gate_receipt_value),
        .gate_receipt_valid(gate_receipt_valid), .alu_rcpt_req(alu_rcpt_req),
        .alu_rcpt_ack(alu_rcpt_ack), .alu_rcpt_value(alu_rcpt_value),
        .busy(busy), .stat_issued(stat_issued), .stat_denied(stat_denied)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        allowed;
        logic [31:0] status;
        int          lat;
        int          rq_cyc;
        int          rp_cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rcpt_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int m_last   = NREQ - 1;
    int m_issued = 0;
    int m_denied = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_note(input string name);
        n_checks++;
        $display("FAIL %s: got event/none expected other at %0t", name, $time);
    endtask

    function automatic logic [31:0] mk(input logic [15:0] st, input logic [4:0] d,
                                       input logic acc, input logic rq, input logic part,
                                       input logic cst, input logic alw);
        return {st, 3'b000, d, 3'b000, acc, rq, part, cst, alw};
    endfunction

    // Expected response, computed from the scheduler's rules for one instruction.
    function automatic exp_t model(input int id, input logic [31:0] ins);
        exp_t e;
        int   d;
        d        = int'(ins[12:8]);
        e.id     = id;
        e.status = {16'h0, ins[31:16]};
        if (!ins[3]) begin
            e.allowed = ins[0] & ins[1] & ins[2];
            e.lat = 3;  e.rq_cyc = 0;  e.rp_cnt = 0;
        end else if (d < TIMEOUT) begin
            e.allowed = ins[4];
            e.lat = 6 + d;  e.rq_cyc = d + 1;  e.rp_cnt = 1;
        end else begin
            e.allowed = 1'b0;
            e.status  = SEQ_TIMEOUT;
            e.lat = 3 + TIMEOUT;  e.rq_cyc = TIMEOUT;  e.rp_cnt = 0;
        end
        return e;
    endfunction

    // mu_core stand-in: its decision is decoded from the presented instruction.
    initial begin
        gate_instr_allowed = 0; gate_cost_open = 0; gate_partition_open = 0;
        gate_receipt_required = 0; gate_receipt_accepted = 0; gate_core_status = '0;
        forever begin
            @(negedge clk);
            if (gate_instr_valid) begin
                gate_instr_allowed    = gate_instruction[0];
                gate_cost_open        = gate_instruction[1];
                gate_partition_open   = gate_instruction[2];
                gate_receipt_required = gate_instruction[3];
                gate_receipt_accepted = gate_instruction[4];
                gate_core_status      = {16'h0, gate_instruction[31:16]};
            end else begin
                gate_instr_allowed = 0; gate_cost_open = 0; gate_partition_open = 0;
                gate_receipt_required = 0; gate_receipt_accepted = 0; gate_core_status = '0;
            end
        end
    end

    // u-ALU stand-in: acks after the delay encoded in the instruction.
    initial begin
        int acnt;
        acnt = 0;
        alu_rcpt_ack = 0;
        alu_rcpt_value = '0;
        forever begin
            @(negedge clk);
            alu_rcpt_ack = 1'b0;
            if (alu_rcpt_req) begin
                if (acnt == int'(gate_instruction[12:8])) begin
                    alu_rcpt_ack   = 1'b1;
                    alu_rcpt_value = $urandom;
                    rcpt_q.push_back(alu_rcpt_value);
                end
                acnt++;
            end else begin
                acnt = 0;
            end
        end
    end

    // Monitor: grant order, issue contents, receipt, gap and response checks.
    initial begin
        int   cyc, grant_cyc, rq_cyc, rp_cnt, low_run, g, idx;
        logic prev_giv, seen_high;
        exp_t e;
        cyc = 0; grant_cyc = 0; rq_cyc = 0; rp_cnt = 0; low_run = 0;
        prev_giv = 0; seen_high = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_giv = 0; seen_high = 0; low_run = 0; rq_cyc = 0; rp_cnt = 0;
                continue;
            end
            cyc++;
            if (req_ready != '0) begin
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (g < 0 && rv[idx]) g = idx;
                end
                if (g < 0) fail_note("grant_without_request");
                else begin
                    chk("grant_rr", 32'(req_ready), 32'(1) << g);
                    chk("issue_instr", gate_instruction, ri[g]);
                    chk("issue_cost", gate_proposed_cost, rc[g]);
                    chk("issue_valid", 32'(gate_instr_valid), 32'd1);
                    m_last = g;
                end
                m_issued++;
                chk("stat_issued", 32'(stat_issued), 32'(m_issued));
                grant_cyc = cyc; rq_cyc = 0; rp_cnt = 0;
            end
            if (alu_rcpt_req) rq_cyc++;
            if (gate_receipt_valid) begin
                rp_cnt++;
                if (rcpt_q.size() == 0) fail_note("receipt_unexpected");
                else chk("receipt_value", gate_receipt_value, rcpt_q.pop_front());
            end
            if (gate_instr_valid) begin
                if (!prev_giv && seen_high) chk("instr_valid_gap_ge2", 32'(low_run >= 2), 32'd1);
                seen_high = 1; low_run = 0;
            end else begin
                low_run++;
            end
            prev_giv = gate_instr_valid;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) fail_note("rsp_unexpected");
                else begin
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_valid), 32'(1) << e.id);
                    chk("rsp_allowed", 32'(rsp_allowed), 32'(e.allowed));
                    chk("rsp_status", rsp_status, e.status);
                    chk("latency", 32'(cyc - grant_cyc), 32'(e.lat));
                    chk("rcpt_req_cycles", 32'(rq_cyc), 32'(e.rq_cyc));
                    chk("rcpt_pulses", 32'(rp_cnt), 32'(e.rp_cnt));
                    if (!e.allowed) m_denied++;
                    chk("stat_denied", 32'(stat_denied), 32'(m_denied));
                    $display("txn req=%0d allowed=%0b status=%h lat=%0d", e.id, rsp_allowed,
                             rsp_status, cyc - grant_cyc);
                end
            end
        end
    end

    task automatic do_req(input int i, input logic [31:0] ins, input logic [31:0] cst,
                          input int withdraw_after);
        int n;
        n = 0;
        rv[i] = 1'b1; ri[i] = ins; rc[i] = cst;
        forever begin
            @(negedge clk);
            if (req_ready[i]) begin
                sb.push_back(model(i, ins));
                rv[i] = 1'b0;
                break;
            end
            if (withdraw_after >= 0 && n >= withdraw_after) begin
                rv[i] = 1'b0;
                break;
            end
            n++;
            if (n > 4000) begin
                fail_note("grant_wait_bound");
                rv[i] = 1'b0;
                break;
            end
        end
    endtask

    task automatic rand_req(input int i, input int n);
        for (int t = 0; t < n; t++) begin
            logic [31:0] ins;
            int          w;
            ins       = $urandom;
            ins[12:8] = 5'($urandom_range(0, 19));
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_req(i, ins, $urandom, w);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_note("drain_bound");
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {20'h0, req_ready, rsp_valid, rsp_allowed, gate_instr_valid,
                            gate_receipt_valid, alu_rcpt_req}, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_stats"}, {stat_issued, stat_denied}, 32'h0);
        chk({tag, "_status"}, rsp_status, 32'h0);
        chk({tag, "_instr"}, gate_instruction, 32'h0);
        chk({tag, "_rcpt"}, gate_receipt_value, 32'h0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0; ri[i] = '0; rc[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: plain allow, receipt accept, timeout, partition closed,
        // ack on the last allowed cycle, and first cycle past the limit.
        do_req(0, mk(16'd2, 5'd0, 0, 0, 1, 1, 1), 32'h0000_0100, -1); wait_idle();
        do_req(1, mk(16'd5, 5'd2, 1, 1, 1, 1, 1), 32'h0000_0200, -1); wait_idle();
        do_req(2, mk(16'd7, 5'd20, 1, 1, 1, 1, 1), 32'h0000_0300, -1); wait_idle();
        do_req(3, mk(16'd4, 5'd0, 0, 0, 0, 1, 1), 32'h0000_0400, -1); wait_idle();
        do_req(0, mk(16'd9, 5'd15, 1, 1, 1, 1, 1), 32'h0000_0500, -1); wait_idle();
        do_req(1, mk(16'd9, 5'd16, 1, 1, 1, 1, 1), 32'h0000_0600, -1); wait_idle();

        // Two requesters held continuously: round-robin alternation.
        fork
            begin repeat (4) do_req(0, mk(16'h10, 5'd0, 0, 0, 1, 1, 1), $urandom, -1); end
            begin repeat (4) do_req(2, mk(16'h20, 5'd1, 1, 1, 1, 1, 1), $urandom, -1); end
        join
        wait_idle();

        // Randomised traffic from all requesters.
        fork
            rand_req(0, 12);
            rand_req(1, 12);
            rand_req(2, 12);
            rand_req(3, 12);
        join
        wait_idle();

        // Reset while waiting for a receipt: the instruction is aborted.
        do_req(0, mk(16'h77, 5'd31, 1, 1, 1, 1, 1), 32'h0000_0777, -1);
        n = 0;
        while (!alu_rcpt_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!alu_rcpt_req) fail_note("rcpt_req_never_raised");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb.delete();
        rcpt_q.delete();
        m_last = NREQ - 1; m_issued = 0; m_denied = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After reset, requester 0 wins over requester 1.
        fork
            do_req(1, mk(16'h31, 5'd0, 0, 0, 1, 1, 1), 32'h11, -1);
            do_req(0, mk(16'h30, 5'd0, 0, 0, 1, 1, 1), 32'h10, -1);
        join
        wait_idle();
        chk("final_stat_issued", 32'(stat_issued), 32'(m_issued));
        chk("final_stat_denied", 32'(stat_denied), 32'(m_denied));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
